// File: rtl/sum_n_arbiter.sv
// sum_n_arbiter: round-robin arbiter sharing one sum_N unit among NREQ requesters.
// Define SUM_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles (rsp_err flags it).
module sum_n_arbiter #(
  parameter int NREQ    = 4,
  parameter int N_W     = 3,
  parameter int S_W     = 5,
  parameter int TIMEOUT = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*N_W-1:0] req_n,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [S_W-1:0]      rsp_sum,
  output logic                rsp_err,
  output logic                busy,
  output logic [N_W-1:0]      unit_n,
  output logic                unit_n_valid,
  output logic                unit_ack,
  input  logic [S_W-1:0]      unit_sum,
  input  logic                unit_sum_valid
);
  localparam int I_W = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state_q, state_d;
  logic [I_W-1:0] rr_q, rr_d, idx_q, idx_d, win_idx, j;
  logic [N_W-1:0] req_n_a [NREQ];
  logic [N_W-1:0] win_n, unit_n_q, unit_n_d;
  logic [NREQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic [S_W-1:0] rsp_sum_q, rsp_sum_d;
  logic win_found, start, bypass, done, tmo;
  logic rsp_err_q, rsp_err_d, busy_q, unit_n_valid_q, unit_ack_q;
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_param_chk
    $error("sum_n_arbiter: NREQ must be 2..8 and TIMEOUT >= 2");
  end
  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign req_n_a[g] = req_n[g*N_W +: N_W];
  end
  always_comb begin
    win_found = 1'b0;
    win_idx = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = I_W'((int'(rr_q) + k) % NREQ);
      win_idx = req[j] ? j : win_idx;
      win_found = win_found | req[j];
    end
  end
  assign win_n = req_n_a[win_idx];
  // No arbitration while a bypass response is out: its requester still holds req.
  assign start = state_q == IDLE && win_found && rsp_valid_q == '0;
  assign bypass = start && win_n == '0;
  assign done = state_q == WAIT && (unit_sum_valid || tmo);
`ifdef SUM_ARB_TIMEOUT_EN
  localparam int C_W = $clog2(TIMEOUT + 1);
  logic [C_W-1:0] cnt_q;
  assign tmo = state_q == WAIT && cnt_q == C_W'(TIMEOUT - 1);
  assign rsp_err_d = done && !unit_sum_valid;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= state_q == WAIT ? cnt_q + C_W'(1) : '0;
`else
  assign tmo = 1'b0;
  assign rsp_err_d = 1'b0;
`endif
  always_comb begin
    state_d = state_q == IDLE  ? ((start && !bypass) ? ISSUE : IDLE)
            : state_q == ISSUE ? WAIT
            : state_q == WAIT  ? (done ? ACK : WAIT)
            : IDLE;
  end
  always_comb begin
    idx_d = start ? win_idx : idx_q;
    unit_n_d = (start && !bypass) ? win_n : unit_n_q;
    gnt_d = (bypass || state_d != IDLE) ? NREQ'(1) << idx_d : '0;
    rsp_valid_d = (bypass || done) ? NREQ'(1) << idx_d : '0;
    rsp_sum_d = done ? (unit_sum_valid ? unit_sum : '0) : bypass ? '0 : rsp_sum_q;
    rr_d = bypass ? (win_idx == I_W'(NREQ - 1) ? '0 : win_idx + I_W'(1))
         : state_q == ACK ? (idx_q == I_W'(NREQ - 1) ? '0 : idx_q + I_W'(1))
         : rr_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      idx_q <= '0;
      gnt_q <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q <= '0;
      rsp_err_q <= 1'b0;
      busy_q <= 1'b0;
      unit_n_q <= '0;
      unit_n_valid_q <= 1'b0;
      unit_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      idx_q <= idx_d;
      gnt_q <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_err_q <= rsp_err_d;
      busy_q <= state_d != IDLE;
      unit_n_q <= unit_n_d;
      unit_n_valid_q <= state_d == ISSUE;
      unit_ack_q <= state_d == ACK;
    end
  end
  assign gnt = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum = rsp_sum_q;
  assign rsp_err = rsp_err_q;
  assign busy = busy_q;
  assign unit_n = unit_n_q;
  assign unit_n_valid = unit_n_valid_q;
  assign unit_ack = unit_ack_q;
endmodule

// File: tb/tb_sum_n_arbiter.sv
// tb_sum_n_arbiter: randomized self-checking bench for sum_n_arbiter with a behavioural sum_N unit.
module tb_sum_n_arbiter;
  localparam int NREQ = 4, N_W = 3, S_W = 5;
  logic clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*N_W-1:0] req_n = '0;
  logic [NREQ-1:0] gnt, rsp_valid;
  logic [S_W-1:0] rsp_sum, unit_sum, mdl_sum = '0, man_sum = '0;
  logic rsp_err, busy, unit_n_valid, unit_ack, unit_sum_valid;
  logic mdl_valid = 1'b0, man_valid = 1'b0, unit_silent = 1'b0;
  logic [N_W-1:0] unit_n;
  int n_checks = 0, n_fail = 0, m_rr = 0;

  assign unit_sum_valid = mdl_valid | man_valid;
  assign unit_sum = man_valid ? man_sum : mdl_sum;

  sum_n_arbiter #(.NREQ(NREQ), .N_W(N_W), .S_W(S_W), .TIMEOUT(31)) dut (
    .clk(clk), .reset(reset), .req(req), .req_n(req_n), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_err(rsp_err), .busy(busy),
    .unit_n(unit_n), .unit_n_valid(unit_n_valid), .unit_ack(unit_ack),
    .unit_sum(unit_sum), .unit_sum_valid(unit_sum_valid));

  always #5 clk = ~clk;

  // sum_N unit: answers N(N+1)/2 exactly N+1 cycles after the issue strobe
  initial forever begin
    @(posedge clk); #1;
    if (unit_n_valid && !unit_silent) begin
      automatic int n = int'(unit_n);
      repeat (n + 1) @(posedge clk);
      #1; mdl_sum = S_W'(n * (n + 1) / 2); mdl_valid = 1'b1;
      @(posedge clk); #1; mdl_valid = 1'b0;
    end
  end

  function automatic int pick(input logic [NREQ-1:0] mask, input int rr);
    for (int k = 0; k < NREQ; k++) if (mask[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  function automatic int slice_n(input logic [NREQ*N_W-1:0] v, input int i);
    return int'(v >> (i * N_W)) % (1 << N_W);
  endfunction

  task automatic tick;
    @(posedge clk); #2;
  endtask

  task automatic observe(input int max, input bit scramble, output int cyc, output int usv_cyc,
                         output int nv_cnt, output int nv_n, output logic [NREQ-1:0] gnt_first,
                         output bit gnt_hold, output bit busy_hold, output bit tout);
    cyc = 0; usv_cyc = -1; nv_cnt = 0; nv_n = -1; gnt_first = '0;
    gnt_hold = 1'b1; busy_hold = 1'b1; tout = 1'b1;
    while (cyc < max) begin
      tick();
      cyc++;
      if (unit_n_valid) begin nv_cnt++; nv_n = int'(unit_n); end
      if (unit_sum_valid) usv_cyc = cyc;
      if (cyc == 1) gnt_first = gnt;
      if (gnt !== gnt_first) gnt_hold = 1'b0;
      if (busy !== 1'b1) busy_hold = 1'b0;
      if (scramble && cyc == 1) req_n = ~req_n;
      if (rsp_valid !== '0) begin tout = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; req_n = '0;
    repeat (2) tick();
    n_checks++; if ({gnt, rsp_valid} !== '0) begin n_fail++; $display("FAIL reset_gnt_rsp: got %b want 0", {gnt, rsp_valid}); end
    n_checks++; if (rsp_sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %0d want 0", rsp_sum); end
    n_checks++; if ({busy, rsp_err, unit_n_valid, unit_ack, unit_n} !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", {busy, rsp_err, unit_n_valid, unit_ack, unit_n}); end
    reset = 1'b0; m_rr = 0;
    tick();
  endtask

  task automatic test_round_robin;
    int cyc, usv, nvc, nvn, w; logic [NREQ-1:0] gf; bit gh, bh, to;
    req = '1; req_n = {NREQ{3'd1}};
    for (int t = 0; t < 5; t++) begin
      w = pick(req, m_rr);
      observe(20, 1'b0, cyc, usv, nvc, nvn, gf, gh, bh, to);
      n_checks++; if (to || rsp_valid !== NREQ'(1 << w)) begin n_fail++; $display("FAIL rr_order[%0d]: rsp_valid=%b want %b", t, rsp_valid, NREQ'(1 << w)); end
      n_checks++; if (rsp_sum !== 5'd1) begin n_fail++; $display("FAIL rr_sum[%0d]: got %0d want 1", t, rsp_sum); end
      n_checks++; if (nvc !== 1) begin n_fail++; $display("FAIL rr_issue_count[%0d]: got %0d want 1", t, nvc); end
      m_rr = (w + 1) % NREQ;
    end
    req = '0; tick();
  endtask

  task automatic test_single;
    int cyc, usv, nvc, nvn; logic [NREQ-1:0] gf; bit gh, bh, to;
    req = 4'b0001; req_n = {9'($urandom), 3'd3};
    observe(20, 1'b0, cyc, usv, nvc, nvn, gf, gh, bh, to);
    n_checks++; if (to || cyc !== 6) begin n_fail++; $display("FAIL single_latency: got %0d cycles (timeout=%0d) want 6", cyc, to); end
    n_checks++; if (nvc !== 1 || nvn !== 3) begin n_fail++; $display("FAIL single_issue: pulses=%0d n=%0d want 1 and 3", nvc, nvn); end
    n_checks++; if (rsp_valid !== 4'b0001 || rsp_sum !== 5'd6) begin n_fail++; $display("FAIL single_rsp: valid=%b sum=%0d want 0001 and 6", rsp_valid, rsp_sum); end
    n_checks++; if (unit_ack !== 1'b1 || usv !== cyc - 1) begin n_fail++; $display("FAIL single_ack: ack=%b usv_cycle=%0d want 1 and %0d", unit_ack, usv, cyc - 1); end
    m_rr = 1; req = '0; tick();
  endtask

  task automatic test_max_n;
    int cyc, usv, nvc, nvn; logic [NREQ-1:0] gf; bit gh, bh, to;
    req = 4'b0100; req_n = 12'b000_111_000_000;
    observe(20, 1'b0, cyc, usv, nvc, nvn, gf, gh, bh, to);
    n_checks++; if (to || rsp_sum !== 5'd28 || cyc !== 10) begin n_fail++; $display("FAIL max_sum: sum=%0d cycles=%0d want 28 and 10", rsp_sum, cyc); end
    n_checks++; if (gf !== 4'b0100 || !gh) begin n_fail++; $display("FAIL max_gnt_hold: first=%b held=%0d want 0100 and 1", gf, gh); end
    n_checks++; if (!bh) begin n_fail++; $display("FAIL max_busy: busy dropped, want high through ACK"); end
    m_rr = 3; req = '0; tick();
    n_checks++; if ({busy, gnt} !== '0) begin n_fail++; $display("FAIL max_release: busy/gnt=%b want 0", {busy, gnt}); end
  endtask

  task automatic test_bypass;
    int cyc, usv, nvc, nvn, w; logic [NREQ-1:0] gf; bit gh, bh, to;
    req = 4'b0010; req_n = 12'b101_011_000_110;
    observe(20, 1'b0, cyc, usv, nvc, nvn, gf, gh, bh, to);
    n_checks++; if (to || cyc !== 1 || rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL bypass_rsp: cycles=%0d valid=%b want 1 and 0010", cyc, rsp_valid); end
    n_checks++; if (rsp_sum !== '0 || gnt !== 4'b0010 || busy !== 1'b0) begin n_fail++; $display("FAIL bypass_out: sum=%0d gnt=%b busy=%b want 0 0010 0", rsp_sum, gnt, busy); end
    m_rr = 2; req = '0; tick();
    n_checks++; if (nvc !== 0 || unit_n_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_unit: pulses=%0d want 0", nvc); end
    req = '1; req_n = {NREQ{3'd2}}; w = pick(req, m_rr);
    observe(20, 1'b0, cyc, usv, nvc, nvn, gf, gh, bh, to);
    n_checks++; if (to || rsp_valid !== NREQ'(1 << w) || rsp_sum !== 5'd3) begin n_fail++; $display("FAIL bypass_rr_ptr: valid=%b sum=%0d want %b and 3", rsp_valid, rsp_sum, NREQ'(1 << w)); end
    m_rr = (w + 1) % NREQ; req = '0; tick();
  endtask

  task automatic test_reset_mid;
    int cyc, usv, nvc, nvn; logic [NREQ-1:0] gf; bit gh, bh, to;
    req = 4'b0001; req_n = 12'd5;
    repeat (3) tick();
    #1 reset = 1'b1;
    #1;
    n_checks++; if ({gnt, rsp_valid, rsp_sum, rsp_err, busy, unit_n, unit_n_valid, unit_ack} !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %b want 0", {gnt, rsp_valid, rsp_sum, rsp_err, busy, unit_n, unit_n_valid, unit_ack}); end
    req = '0; tick(); reset = 1'b0; m_rr = 0;
    observe(12, 1'b0, cyc, usv, nvc, nvn, gf, gh, bh, to);
    n_checks++; if (!to || nvc !== 0) begin n_fail++; $display("FAIL midreset_quiet: rsp_valid=%b pulses=%0d want no response", rsp_valid, nvc); end
    req = 4'b0100; req_n = 12'b000_010_000_000;
    observe(20, 1'b0, cyc, usv, nvc, nvn, gf, gh, bh, to);
    n_checks++; if (to || rsp_valid !== 4'b0100 || rsp_sum !== 5'd3 || cyc !== 5) begin n_fail++; $display("FAIL midreset_next: valid=%b sum=%0d cycles=%0d want 0100 3 5", rsp_valid, rsp_sum, cyc); end
    m_rr = 3; req = '0; tick();
  endtask

  task automatic test_wait_bound;
    int cyc, usv, nvc, nvn; logic [NREQ-1:0] gf; bit gh, bh, to;
    unit_silent = 1'b1; req = 4'b0001; req_n = 12'd4;
`ifdef SUM_ARB_TIMEOUT_EN
    observe(40, 1'b0, cyc, usv, nvc, nvn, gf, gh, bh, to);
    n_checks++; if (to || cyc !== 33 || rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL timeout_rsp: cycles=%0d valid=%b want 33 and 0001", cyc, rsp_valid); end
    n_checks++; if (rsp_err !== 1'b1 || rsp_sum !== '0 || unit_ack !== 1'b1) begin n_fail++; $display("FAIL timeout_flags: err=%b sum=%0d ack=%b want 1 0 1", rsp_err, rsp_sum, unit_ack); end
`else
    observe(60, 1'b0, cyc, usv, nvc, nvn, gf, gh, bh, to);
    n_checks++; if (!to || busy !== 1'b1 || gnt !== 4'b0001 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL unbounded_wait: valid=%b busy=%b gnt=%b err=%b want 0000 1 0001 0", rsp_valid, busy, gnt, rsp_err); end
    man_sum = 5'd10; man_valid = 1'b1; tick(); man_valid = 1'b0;
    n_checks++; if (rsp_valid !== 4'b0001 || rsp_sum !== 5'd10 || rsp_err !== 1'b0 || unit_ack !== 1'b1) begin n_fail++; $display("FAIL late_result: valid=%b sum=%0d err=%b ack=%b want 0001 10 0 1", rsp_valid, rsp_sum, rsp_err, unit_ack); end
`endif
    m_rr = 1; req = '0; unit_silent = 1'b0; tick();
  endtask

  task automatic test_random;
    int cyc, usv, nvc, nvn, w, n; logic [NREQ-1:0] gf; bit gh, bh, to, scr;
    for (int t = 0; t < 40; t++) begin
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1)); req_n = (NREQ*N_W)'($urandom);
      w = pick(req, m_rr); n = slice_n(req_n, w); scr = 1'($urandom_range(0, 1));
      observe(20, scr, cyc, usv, nvc, nvn, gf, gh, bh, to);
      n_checks++; if (to || rsp_valid !== NREQ'(1 << w)) begin n_fail++; $display("FAIL rand_winner[%0d]: valid=%b want %b", t, rsp_valid, NREQ'(1 << w)); end
      n_checks++; if (rsp_sum !== S_W'(n * (n + 1) / 2) || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rand_sum[%0d]: sum=%0d err=%b want %0d 0 (n=%0d)", t, rsp_sum, rsp_err, n * (n + 1) / 2, n); end
      n_checks++; if (cyc !== (n == 0 ? 1 : n + 3)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", t, cyc, n == 0 ? 1 : n + 3); end
      n_checks++; if (nvc !== (n != 0 ? 1 : 0) || unit_ack !== (n != 0)) begin n_fail++; $display("FAIL rand_unit[%0d]: pulses=%0d ack=%b n=%0d", t, nvc, unit_ack, n); end
      if (n != 0) begin
        n_checks++; if (nvn !== n) begin n_fail++; $display("FAIL rand_unit_n[%0d]: got %0d want %0d", t, nvn, n); end
      end
      m_rr = (w + 1) % NREQ; req = '0; tick();
      n_checks++; if ({busy, gnt, rsp_valid} !== '0) begin n_fail++; $display("FAIL rand_idle[%0d]: busy/gnt/valid=%b want 0", t, {busy, gnt, rsp_valid}); end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_max_n();
    test_bypass();
    test_reset_mid();
    test_wait_bound();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
